// File: rtl/uart_bus_arbiter_pkg.sv
// Shared definitions for the uart register-port arbiter: register addresses,
// bus direction encoding and the access sequencer state encoding.
package uart_bus_arbiter_pkg;

    localparam logic [1:0] UART_TX_ADDR = 2'd0;
    localparam logic [1:0] UART_RX_ADDR = 2'd1;

    // uart convention: high means read
    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StClkHi = 3'd2,
        StWait  = 3'd3,
        StDone  = 3'd4
    } state_e;

endpackage

// File: rtl/uart_rr_arb.sv
// Two-way round-robin grant with the last_grant history register.
// The requester that did not win last time takes a tie.
module uart_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic grant_valid,
    output logic grant,
    output logic last_grant
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else begin
            grant = req1;
        end
    end

    // Reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (en && grant_valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares the uart register port between two requesters and sequences each access.
// Define UART_ARB_TIMEOUT_EN to enable the wait-state timeout and err0/err1.
module uart_bus_arbiter
    import uart_bus_arbiter_pkg::*;
#(
    parameter int unsigned CLK_HALF       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data_in,
    output logic       wb_we,
    output logic       wb_stb,
    output logic       wb_clk,
    input  logic [7:0] wb_data_out,
    input  logic       wb_ack
);

    localparam logic [3:0] PhaseLast = 4'(CLK_HALF - 1);
    localparam logic [7:0] TmoLast   = 8'(TIMEOUT_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic       owner_q;
    logic       grant_valid;
    logic       grant;
    logic       last_grant;
    logic       timed_out;
    logic       finish;
    logic       abort;

    uart_rr_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .en          (state_q == StIdle),
        .req0        (req0),
        .req1        (req1),
        .grant_valid (grant_valid),
        .grant       (grant),
        .last_grant  (last_grant)
    );

`ifdef UART_ARB_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;

    assign timed_out = (tmo_q == TmoLast);

    // Counts WAIT cycles; the access gives up once it has seen TIMEOUT_CYCLES of them
    always_comb begin
        tmo_d = 8'd0;
        if (state_q == StWait && !timed_out) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign unused_timeout = ^TmoLast;
`endif

    // Ack beats a simultaneous timeout
    assign finish = (state_q == StWait) && (wb_ack || timed_out);
    assign abort  = (state_q == StWait) && !wb_ack && timed_out;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        unique case (state_q)
            StIdle: begin
                phase_d = 4'd0;
                if (grant_valid) begin
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (phase_q == PhaseLast) begin
                    phase_d = 4'd0;
                    state_d = StClkHi;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StClkHi: begin
                if (phase_q == PhaseLast) begin
                    phase_d = 4'd0;
                    state_d = StWait;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StWait: begin
                if (finish) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                phase_d = 4'd0;
            end
        endcase
    end

    // Bus-side outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            phase_q    <= 4'd0;
            owner_q    <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata      <= 8'd0;
            wb_addr    <= 2'd0;
            wb_data_in <= 8'd0;
            wb_we      <= BUS_WRITE;
            wb_stb     <= 1'b0;
            wb_clk     <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wb_stb  <= (state_d == StSetup) || (state_d == StClkHi) || (state_d == StWait);
            wb_clk  <= (state_d == StClkHi);
            done0   <= finish && !owner_q;
            done1   <= finish && owner_q;
            err0    <= abort && !owner_q;
            err1    <= abort && owner_q;

            if (state_q == StIdle && grant_valid) begin
                owner_q    <= grant;
                wb_addr    <= grant ? addr1 : addr0;
                wb_we      <= grant ? we1 : we0;
                wb_data_in <= grant ? wdata1 : wdata0;
            end

            if (state_q == StWait && wb_ack && wb_we == BUS_READ) begin
                rdata <= wb_data_out;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed self-checking bench for uart_bus_arbiter with default parameters.
// Checks follow the timeout behaviour selected by UART_ARB_TIMEOUT_EN.
module tb_uart_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [1:0] addr0, addr1;
    logic       we0, we1;
    logic [7:0] wdata0, wdata1;
    logic       done0, done1, err0, err1;
    logic [7:0] rdata;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_in;
    logic       wb_we, wb_stb, wb_clk;
    logic [7:0] wb_data_out;
    logic       wb_ack;

    logic man_ack;
    logic auto_ack;
    logic seen_hi;

    int n_assert = 0;
    int n_fail   = 0;

    int         r_rise, r_hi, r_done;
    logic       r_err, r_other, r_stb1, r_we1, r_stb_done;
    logic [7:0] r_data1;
    logic [1:0] r_addr1;

    int c_who[4];
    int c_when[4];

    always #5 clk = ~clk;

    uart_bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .addr0       (addr0),
        .addr1       (addr1),
        .we0         (we0),
        .we1         (we1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .done0       (done0),
        .done1       (done1),
        .err0        (err0),
        .err1        (err1),
        .rdata       (rdata),
        .wb_addr     (wb_addr),
        .wb_data_in  (wb_data_in),
        .wb_we       (wb_we),
        .wb_stb      (wb_stb),
        .wb_clk      (wb_clk),
        .wb_data_out (wb_data_out),
        .wb_ack      (wb_ack)
    );

    // Simple uart model: acks in the first low-clock cycle after a bus-clock pulse
    always_ff @(posedge clk) begin
        seen_hi <= wb_stb ? (seen_hi | wb_clk) : 1'b0;
    end

    assign wb_ack = auto_ack ? (wb_stb && !wb_clk && seen_hi) : man_ack;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request starting in an IDLE cycle (cycle 0); ack driven in cycle ack_cycle
    task automatic access(input bit who, input logic [1:0] a, input logic w,
                          input logic [7:0] d, input int ack_cycle, input int budget);
        r_rise = -1; r_hi = 0; r_done = -1; r_err = 1'b0; r_other = 1'b0;
        r_stb1 = 1'b0; r_we1 = 1'b0; r_data1 = 8'd0; r_addr1 = 2'd0; r_stb_done = 1'b1;
        if (who) begin
            req1 = 1'b1; addr1 = a; we1 = w; wdata1 = d;
        end else begin
            req0 = 1'b1; addr0 = a; we0 = w; wdata0 = d;
        end
        for (int k = 1; k <= budget && r_done < 0; k++) begin
            step();
            man_ack = (k == ack_cycle);
            if (k == 1) begin
                r_stb1 = wb_stb; r_data1 = wb_data_in; r_addr1 = wb_addr; r_we1 = wb_we;
            end
            if (wb_clk) begin
                if (r_rise < 0) r_rise = k;
                r_hi++;
            end
            if (who ? done0 : done1) r_other = 1'b1;
            if (who ? done1 : done0) begin
                r_done = k;
                r_err = who ? err1 : err0;
                r_stb_done = wb_stb;
            end
        end
        man_ack = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
    endtask

    // Both requesters held high from cycle 0; records which one completes and when
    task automatic contend(input int n);
        int cnt = 0;
        auto_ack = 1'b1;
        req0 = 1'b1; addr0 = 2'd0; we0 = 1'b0; wdata0 = 8'h0A;
        req1 = 1'b1; addr1 = 2'd0; we1 = 1'b0; wdata1 = 8'h1B;
        for (int i = 0; i < 4; i++) begin
            c_who[i] = -1;
            c_when[i] = -1;
        end
        for (int k = 1; k <= 60 && cnt < n; k++) begin
            step();
            if (done0) begin
                c_who[cnt] = 0; c_when[cnt] = k; cnt++;
            end else if (done1) begin
                c_who[cnt] = 1; c_when[cnt] = k; cnt++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        auto_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 2'd0; addr1 = 2'd0; we0 = 1'b0; we1 = 1'b0;
        wdata0 = 8'd0; wdata1 = 8'd0; wb_data_out = 8'd0;
        man_ack = 1'b0; auto_ack = 1'b0;
        step();
        step();

        check("reset_done", {done1, done0}, 2'b00);
        check("reset_err", {err1, err0}, 2'b00);
        check("reset_rdata", rdata, 8'h00);
        check("reset_bus", {wb_addr, wb_data_in, wb_we}, 11'h000);
        check("reset_stb_clk", {wb_stb, wb_clk}, 2'b00);
        reset = 1'b0;
        step();

        // Single write from requester 0
        access(1'b0, 2'd0, 1'b0, 8'h42, 9, 30);
        check("wr_stb_c1", r_stb1, 1'b1);
        check("wr_data", r_data1, 8'h42);
        check("wr_addr_we", {r_addr1, r_we1}, 3'b000);
        check("wr_clk_rise", r_rise, 5);
        check("wr_clk_high", r_hi, 4);
        check("wr_done_cyc", r_done, 10);
        check("wr_err", r_err, 1'b0);
        check("wr_other_done", r_other, 1'b0);
        check("wr_rdata", rdata, 8'h00);

        // Read of 'G' by requester 1
        wb_data_out = 8'h47;
        access(1'b1, 2'd1, 1'b1, 8'h00, 9, 30);
        check("rd_addr_we", {r_addr1, r_we1}, 3'b011);
        check("rd_done_cyc", r_done, 10);
        check("rd_other_done", r_other, 1'b0);
        check("rd_rdata", rdata, 8'h47);

        // A write must not disturb rdata
        wb_data_out = 8'hEE;
        access(1'b1, 2'd0, 1'b0, 8'hA5, 9, 30);
        check("wr2_data", r_data1, 8'hA5);
        check("wr2_rdata", rdata, 8'h47);

        // Ack on the last WAIT cycle before the timeout limit
        wb_data_out = 8'h5A;
        access(1'b0, 2'd1, 1'b1, 8'h00, 24, 40);
        check("edge_done_cyc", r_done, 25);
        check("edge_err", r_err, 1'b0);
        check("edge_rdata", rdata, 8'h5A);

        wb_data_out = 8'h99;
`ifdef UART_ARB_TIMEOUT_EN
        access(1'b0, 2'd1, 1'b1, 8'h00, -1, 40);
        check("tmo_done_cyc", r_done, 25);
        check("tmo_err", r_err, 1'b1);
        check("tmo_stb_at_done", r_stb_done, 1'b0);
        check("tmo_rdata", rdata, 8'h5A);
        check("tmo_stb_after", wb_stb, 1'b0);
`else
        access(1'b0, 2'd1, 1'b1, 8'h00, -1, 1000);
        check("noack_no_done", r_done, -1);
        check("noack_stb", wb_stb, 1'b1);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("late_ack_done", {done1, done0}, 2'b01);
        check("late_ack_err", err0, 1'b0);
        check("late_ack_rdata", rdata, 8'h99);
        step();
`endif

        // Contention from reset: grants alternate starting with requester 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        contend(4);
        check("cont_who0", c_who[0], 0);
        check("cont_who1", c_who[1], 1);
        check("cont_who2", c_who[2], 0);
        check("cont_who3", c_who[3], 1);
        check("cont_when0", c_when[0], 10);
        check("cont_when1", c_when[1], 21);
        check("cont_when2", c_when[2], 32);
        check("cont_when3", c_when[3], 43);

        // Reset during the high phase of the bus clock
        step();
        req0 = 1'b1; addr0 = 2'd0; we0 = 1'b0; wdata0 = 8'h11;
        for (int k = 1; k <= 6; k++) step();
        check("mid_clk_high", wb_clk, 1'b1);
        reset = 1'b1;
        req0 = 1'b0;
        step();
        reset = 1'b0;
        check("mid_stb_clk", {wb_stb, wb_clk}, 2'b00);
        check("mid_done", {done1, done0}, 2'b00);
        begin
            logic seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                step();
                if (done0 || done1 || wb_stb) seen = 1'b1;
            end
            check("mid_quiet", seen, 1'b0);
        end

        // Lone requester 1 is served, then a tie still favours requester 0
        access(1'b1, 2'd0, 1'b0, 8'h33, 9, 30);
        check("post_r1_done", r_done, 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        contend(2);
        check("post_tie_who0", c_who[0], 0);
        check("post_tie_who1", c_who[1], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
